// File: rtl/seq_checker.sv
// rtl/seq_checker.sv - Fibonacci stream checker with registered match/mismatch pulses,
// sticky error flag and a saturating consecutive-match counter.
module seq_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] seq_i,
    output logic             match_o,
    output logic             mismatch_o,
    output logic             error_o,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] expect_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_FAIL  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TERM_ONE = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_prev, w_prev_nxt;
    logic [WIDTH-1:0] r_curr, w_curr_nxt;
    logic             r_match, w_match_nxt;
    logic             r_mismatch, w_mismatch_nxt;
    logic             r_error, w_error_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_prev     <= '0;
            r_curr     <= TERM_ONE;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_error    <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_curr     <= w_curr_nxt;
            r_match    <= w_match_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_error    <= w_error_nxt;
            r_count    <= w_count_nxt;
        end
    end

    // r_curr always holds the next expected term; prev=0/curr=1 yields 1, 1, 2, ...
    always_comb begin
        w_state_nxt    = r_state;
        w_prev_nxt     = r_prev;
        w_curr_nxt     = r_curr;
        w_match_nxt    = 1'b0;
        w_mismatch_nxt = 1'b0;
        w_error_nxt    = r_error;
        w_count_nxt    = r_count;

        if (clear_i) begin
            w_state_nxt = S_IDLE;
            w_prev_nxt  = '0;
            w_curr_nxt  = TERM_ONE;
            w_error_nxt = 1'b0;
            w_count_nxt = '0;
        end else if (valid_i) begin
            case (r_state)
                S_IDLE, S_TRACK: begin
                    if (seq_i == r_curr) begin
                        w_state_nxt = S_TRACK;
                        w_match_nxt = 1'b1;
                        w_prev_nxt  = r_curr;
                        w_curr_nxt  = r_prev + r_curr;
                        w_count_nxt = (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;
                    end else begin
                        w_state_nxt    = S_FAIL;
                        w_mismatch_nxt = 1'b1;
                        w_error_nxt    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_FAIL;
                end
            endcase
        end
    end

    assign match_o    = r_match;
    assign mismatch_o = r_mismatch;
    assign error_o    = r_error;
    assign count_o    = r_count;
    assign expect_o   = r_curr;

endmodule

// File: tb/tb_seq_checker.sv
// tb/tb_seq_checker.sv - scoreboard bench for seq_checker (default and CNT_W=4 instances).
module tb_seq_checker;

    logic        clk;
    logic        reset;
    logic        clear_i;
    logic        valid_i;
    logic [31:0] seq_i;

    logic        m16, mm16, e16;
    logic [15:0] c16;
    logic [31:0] x16;
    logic        m4, mm4, e4;
    logic [3:0]  c4;
    logic [31:0] x4;

    seq_checker dut (
        .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i), .seq_i(seq_i),
        .match_o(m16), .mismatch_o(mm16), .error_o(e16), .count_o(c16), .expect_o(x16)
    );

    seq_checker #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .clear_i(clear_i), .valid_i(valid_i), .seq_i(seq_i),
        .match_o(m4), .mismatch_o(mm4), .error_o(e4), .count_o(c4), .expect_o(x4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          m;
        bit          mm;
        bit          e;
        int          cnt;
        logic [31:0] ex;
    } exp_t;

    typedef struct {
        bit          clr;
        bit          v;
        logic [31:0] s;
        int          pulse;  // -1 model decides, 0 none, 1 match, 2 mismatch
    } vec_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    bit m_fail;
    bit m_err;
    int m_n;

    function automatic logic [31:0] fib(int n);
        logic [31:0] a, b, t;
        a = 32'd1;
        b = 32'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic model_reset();
        m_fail = 1'b0;
        m_err  = 1'b0;
        m_n    = 0;
        sb.delete();
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("match",      64'(m16),  64'(e.m));
            chk("mismatch",   64'(mm16), 64'(e.mm));
            chk("error",      64'(e16),  64'(e.e));
            chk("count",      64'(c16),  64'(e.cnt));
            chk("expect",     64'(x16),  64'(e.ex));
            chk("match4",     64'(m4),   64'(e.m));
            chk("mismatch4",  64'(mm4),  64'(e.mm));
            chk("count4_sat", 64'(c4),   64'((e.cnt > 15) ? 15 : e.cnt));
            chk("expect4",    64'(x4),   64'(e.ex));
        end
    endtask

    task automatic step(bit clr, bit v, logic [31:0] s, int pulse);
        exp_t e;
        @(negedge clk);
        compare_pop();
        clear_i = clr;
        valid_i = v;
        seq_i   = s;
        e.m  = 1'b0;
        e.mm = 1'b0;
        if (clr) begin
            m_fail = 1'b0;
            m_err  = 1'b0;
            m_n    = 0;
        end else if (v && !m_fail) begin
            if (s == fib(m_n)) begin
                m_n++;
                e.m = 1'b1;
            end else begin
                m_fail = 1'b1;
                m_err  = 1'b1;
                e.mm   = 1'b1;
            end
        end
        e.e   = m_err;
        e.cnt = m_n;
        e.ex  = fib(m_n);
        if (pulse >= 0) begin
            e.m  = (pulse == 1);
            e.mm = (pulse == 2);
        end
        sb.push_back(e);
    endtask

    task automatic run_table(vec_t t[$]);
        foreach (t[i]) step(t[i].clr, t[i].v, t[i].s, t[i].pulse);
        step(1'b0, 1'b0, 32'd0, 0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_match"},    64'(m16 | m4),   64'd0);
        chk({tag, "_mismatch"}, 64'(mm16 | mm4), 64'd0);
        chk({tag, "_error"},    64'(e16 | e4),   64'd0);
        chk({tag, "_count"},    64'(c16),        64'd0);
        chk({tag, "_count4"},   64'(c4),         64'd0);
        chk({tag, "_expect"},   64'(x16),        64'd1);
        chk({tag, "_expect4"},  64'(x4),         64'd1);
    endtask

    initial begin
        vec_t t_basic[$];
        vec_t t_fail[$];
        vec_t t_clr[$];

        t_basic = '{
            '{0, 1, 32'd1, 1}, '{0, 1, 32'd1, 1}, '{0, 1, 32'd2, 1}, '{0, 1, 32'd3, 1},
            '{0, 1, 32'd5, 1}, '{0, 1, 32'd8, 1}, '{0, 1, 32'd13, 1}
        };
        t_fail = '{
            '{1, 0, 32'd0, 0},
            '{0, 1, 32'd1, 1}, '{0, 1, 32'd1, 1}, '{0, 1, 32'd2, 1}, '{0, 1, 32'd4, 2},
            '{0, 1, 32'd5, 0}, '{0, 0, 32'd0, 0}, '{0, 1, 32'd8, 0}
        };
        t_clr = '{
            '{1, 0, 32'd0, 0},
            '{0, 1, 32'd1, 1}, '{0, 1, 32'd1, 1}, '{0, 1, 32'd2, 1},
            '{1, 1, 32'd5, 0},
            '{0, 1, 32'd1, 1}, '{0, 1, 32'd1, 1}
        };

        reset   = 1'b0;
        clear_i = 1'b0;
        valid_i = 1'b0;
        seq_i   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;

        run_table(t_basic);
        @(negedge clk);
        compare_pop();
        chk("basic_count_7",   64'(c16), 64'd7);
        chk("basic_expect_21", 64'(x16), 64'd21);
        sb.delete();

        run_table(t_fail);
        @(negedge clk);
        compare_pop();
        chk("fail_count_3", 64'(c16), 64'd3);
        chk("fail_error",   64'(e16), 64'd1);
        sb.delete();

        step(1'b1, 1'b0, 32'd0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, fib(i), 1);
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 32'hdead_beef, 0);
        end
        step(1'b0, 1'b0, 32'd0, 0);
        @(negedge clk);
        compare_pop();
        chk("gap_count_3", 64'(c16), 64'd3);

        step(1'b1, 1'b0, 32'd0, 0);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, fib(i), 1);
        step(1'b0, 1'b0, 32'd0, 0);
        @(negedge clk);
        compare_pop();
        chk("wrap_count_60", 64'(c16), 64'd60);
        chk("wrap_error",    64'(e16), 64'd0);
        chk("wrap_sat4",     64'(c4),  64'd15);

        run_table(t_clr);

        step(1'b1, 1'b0, 32'd0, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, fib(i), 1);
        @(negedge clk);
        compare_pop();
        chk("sat4_20", 64'(c4), 64'd15);
        valid_i = 1'b1;
        seq_i   = fib(20);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(negedge clk);
        check_reset_outputs("rst_hold");
        valid_i = 1'b0;
        reset   = 1'b1;
        step(1'b0, 1'b1, 32'd1, 1);
        step(1'b0, 1'b1, 32'd1, 1);
        step(1'b0, 1'b0, 32'd0, 0);
        @(negedge clk);
        compare_pop();
        chk("post_rst_count", 64'(c16), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
